zports_bank: RTL and testbench



---
 rtl/zports_bank.sv | 244 ++++++++++++++++++++++++
 tb/tb_zports_bank.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zports_bank.sv
// zports_bank: fclk-synchronous Z80 I/O port block.
//
// Decodes one low port byte (PORT_LO). The high address byte selects one of
// NREGS 8-bit configuration registers, or an external data window (EXT_IDX).
// Accesses to the external window are handed to another block through
// ext_req/ext_ack. The Z80 is held on WAIT until that block acknowledges or
// the timeout counter expires.
//
// Optional feature macro: ZPORTS_BANK_READBACK_EN
//   defined   - local registers can be read back through dout
//   undefined - local register reads return 8'hFF with dataout low;
//               the external window can still be read
//
// Ports:
//   fclk, rst          clock, synchronous active-high reset
//   zpos               Z80 clock rising-edge strobe (fclk domain)
//   a, din             Z80 address and write data
//   iorq_n, rd_n, wr_n Z80 bus controls
//   dout, dataout      read data and its drive enable
//   porthit            a[7:0] == PORT_LO
//   regs_out           all register contents, register i at [8i+7:8i]
//   wr_stb             one-fclk pulse per register write
//   ext_addr           register 0, the address for the external window
//   ext_req/ext_rnw/ext_wdata/ext_rdata/ext_ack  external window handshake
//   wait_n             Z80 WAIT
//   err                sticky timeout flag
//
// Wait FSM states:
//   IDLE | no external access; new strobes accepted
//   REQ  | ext_req raised, Z80 held, timeout counter running
//   DONE | access finished, WAIT released, waiting for the Z80 cycle to end
module zports_bank #(
    parameter int                 NREGS   = 4,
    parameter logic [7:0]         PORT_LO = 8'hBF,
    parameter logic [7:0]         EXT_IDX = 8'hFF,
    parameter logic [NREGS*8-1:0] RST_VAL = {NREGS{8'h00}},
    parameter logic [NREGS*8-1:0] WMASK   = {NREGS{8'hFF}},
    parameter int                 TMO_W   = 8
) (
    input  logic               fclk,
    input  logic               rst,
    input  logic               zpos,
    input  logic [15:0]        a,
    input  logic [7:0]         din,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    output logic [7:0]         dout,
    output logic               dataout,
    output logic               porthit,
    output logic [NREGS*8-1:0] regs_out,
    output logic [NREGS-1:0]   wr_stb,
    output logic [7:0]         ext_addr,
    output logic               ext_req,
    output logic               ext_rnw,
    output logic [7:0]         ext_wdata,
    input  logic [7:0]         ext_rdata,
    input  logic               ext_ack,
    output logic               wait_n,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    logic [7:0]         idx;
    logic               s0_wr, s0_rd, s1_wr, s1_rd;
    logic               wr_p, rd_p;
    logic [NREGS*8-1:0] regs_q;
    logic [NREGS-1:0]   we;
    logic               local_sel;
    logic               ext_hit;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               req_q, req_d;
    logic               wait_q, wait_d;
    logic               rnw_q, rnw_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rlatch_q, rlatch_d;
    logic               err_q, err_d;

    assign idx     = a[15:8];
    assign porthit = (a[7:0] == PORT_LO);
    assign ext_hit = porthit && (idx == EXT_IDX);

    // Stage 0 follows the bus only on Z80 clock edges; stage 1 delays it by
    // one fclk, so each I/O cycle yields exactly one single-fclk pulse no
    // matter how many zpos strobes occur while the cycle is active.
    always_ff @(posedge fclk) begin
        if (rst) begin
            s0_wr <= 1'b0;
            s0_rd <= 1'b0;
            s1_wr <= 1'b0;
            s1_rd <= 1'b0;
        end else begin
            if (zpos) begin
                s0_wr <= ~(iorq_n | wr_n);
                s0_rd <= ~(iorq_n | rd_n);
            end
            s1_wr <= s0_wr;
            s1_rd <= s0_rd;
        end
    end

    assign wr_p = s0_wr & ~s1_wr;
    assign rd_p = s0_rd & ~s1_rd;

    // Local registers
    always_comb begin
        we        = '0;
        local_sel = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 8'(i)) begin
                local_sel = 1'b1;
                we[i]     = wr_p & porthit;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            regs_q <= RST_VAL;
            wr_stb <= '0;
        end else begin
            wr_stb <= we;
            for (int i = 0; i < NREGS; i++) begin
                if (we[i]) begin
                    regs_q[8*i +: 8] <= (regs_q[8*i +: 8] & ~WMASK[8*i +: 8])
                                      | (din & WMASK[8*i +: 8]);
                end
            end
        end
    end

    assign regs_out = regs_q;
    assign ext_addr = regs_q[7:0];

    // Read path
`ifdef ZPORTS_BANK_READBACK_EN
    logic [7:0] local_q;

    always_comb begin
        local_q = 8'hFF;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 8'(i)) local_q = regs_q[8*i +: 8];
        end
    end

    always_comb begin
        if (local_sel)           dout = local_q;
        else if (idx == EXT_IDX) dout = rlatch_q;
        else                     dout = 8'hFF;
    end

    assign dataout = porthit & ~iorq_n & ~rd_n;
`else
    always_comb begin
        if (local_sel)           dout = 8'hFF;
        else if (idx == EXT_IDX) dout = rlatch_q;
        else                     dout = 8'hFF;
    end

    assign dataout = porthit & ~iorq_n & ~rd_n & ~local_sel;
`endif

    // Wait FSM: state register
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            wait_q   <= 1'b1;
            rnw_q    <= 1'b1;
            wdata_q  <= 8'h00;
            rlatch_q <= 8'hFF;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            wait_q   <= wait_d;
            rnw_q    <= rnw_d;
            wdata_q  <= wdata_d;
            rlatch_q <= rlatch_d;
            err_q    <= err_d;
        end
    end

    assign cnt_inc = cnt_q + TMO_W'(1);

    // Wait FSM: next state and registered outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        wait_d   = wait_q;
        rnw_d    = rnw_q;
        wdata_d  = wdata_q;
        rlatch_d = rlatch_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (ext_hit && wr_p && din[7]) begin
                    // Error-clear write: no external access is started.
                    err_d = 1'b0;
                end else if (ext_hit && (wr_p || rd_p)) begin
                    rnw_d   = ~wr_p;
                    wdata_d = din;
                    req_d   = 1'b1;
                    wait_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (ext_ack) begin
                    req_d  = 1'b0;
                    wait_d = 1'b1;
                    if (rnw_q) rlatch_d = ext_rdata;
                    state_d = DONE;
                end else if (&cnt_inc) begin
                    // ext_req has now been high for 2^TMO_W-1 cycles.
                    req_d    = 1'b0;
                    wait_d   = 1'b1;
                    rlatch_d = 8'hFF;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!s0_wr && !s0_rd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ext_req   = req_q;
    assign wait_n    = wait_q;
    assign ext_rnw   = rnw_q;
    assign ext_wdata = wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_zports_bank.sv
// Self-checking bench for zports_bank (NREGS=4, reg1 resets to 8'h5A,
// reg2 writable mask 8'h0F, TMO_W=4).
module tb_zports_bank;

    localparam int          NREGS = 4;
    localparam logic [31:0] RSTV  = 32'h0000_5A00;
    localparam logic [31:0] WMSK  = 32'hFF0F_FFFF;
    localparam int          TMO_W = 4;

    logic        fclk = 1'b0;
    logic        rst = 1'b1;
    logic        zpos = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0]  dout;
    logic        dataout, porthit;
    logic [31:0] regs_out;
    logic [3:0]  wr_stb;
    logic [7:0]  ext_addr;
    logic        ext_req, ext_rnw;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata = 8'h00;
    logic        ext_ack = 1'b0;
    logic        wait_n, err;

    int errors = 0;
    int checks = 0;
    int stb_cnt[NREGS] = '{default: 0};
    logic [7:0] exp_q[$];

    zports_bank #(
        .NREGS(NREGS), .PORT_LO(8'hBF), .EXT_IDX(8'hFF),
        .RST_VAL(RSTV), .WMASK(WMSK), .TMO_W(TMO_W)
    ) dut (
        .fclk(fclk), .rst(rst), .zpos(zpos), .a(a), .din(din),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .dout(dout), .dataout(dataout), .porthit(porthit),
        .regs_out(regs_out), .wr_stb(wr_stb), .ext_addr(ext_addr),
        .ext_req(ext_req), .ext_rnw(ext_rnw), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack), .wait_n(wait_n), .err(err)
    );

    always #5 fclk = ~fclk;

    // Z80 clock edge strobe: one fclk in three
    initial begin
        int zc;
        zc = 0;
        forever begin
            @(posedge fclk);
            #1;
            zc = (zc + 1) % 3;
            zpos = (zc == 0);
        end
    end

    always @(negedge fclk) begin
        for (int i = 0; i < NREGS; i++) if (wr_stb[i] === 1'b1) stb_cnt[i]++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_start(input logic wr, input logic [15:0] addr, input logic [7:0] data);
        @(posedge fclk);
        #1;
        a = addr;
        din = data;
        iorq_n = 1'b0;
        if (wr) wr_n = 1'b0;
        else    rd_n = 1'b0;
    endtask

    task automatic bus_end();
        @(posedge fclk);
        #1;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    task automatic local_write(input logic [15:0] addr, input logic [7:0] data);
        bus_start(1'b1, addr, data);
        repeat (10) @(posedge fclk);
        bus_end();
        idle(3);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge fclk);
            if (ext_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge fclk);
        #1 rst = 1'b0;
        @(negedge fclk);
        checks++; if (regs_out !== RSTV) begin errors++; $display("FAIL reset_regs: got %h expected %h", regs_out, RSTV); end
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n: got %b expected 1", wait_n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL reset_ext_req: got %b expected 0", ext_req); end
        checks++; if (ext_rnw !== 1'b1) begin errors++; $display("FAIL reset_ext_rnw: got %b expected 1", ext_rnw); end
        checks++; if (ext_wdata !== 8'h00) begin errors++; $display("FAIL reset_ext_wdata: got %h expected 00", ext_wdata); end
        checks++; if (wr_stb !== 4'h0) begin errors++; $display("FAIL reset_wr_stb: got %b expected 0000", wr_stb); end
        bus_start(1'b0, 16'h01BF, 8'h00);
        repeat (2) @(negedge fclk);
        checks++; if (porthit !== 1'b1) begin errors++; $display("FAIL reset_porthit: got %b expected 1", porthit); end
`ifdef ZPORTS_BANK_READBACK_EN
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL reset_read_reg1: got %h expected 5a", dout); end
        checks++; if (dataout !== 1'b1) begin errors++; $display("FAIL reset_read_oe: got %b expected 1", dataout); end
`else
        checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL reset_read_reg1: got %h expected ff", dout); end
        checks++; if (dataout !== 1'b0) begin errors++; $display("FAIL reset_read_oe: got %b expected 0", dataout); end
`endif
        bus_end();
        idle(3);
    endtask

    task automatic test_masked_write();
        int  base[NREGS];
        bit  seen;
        logic [7:0] exp_v;
        for (int i = 0; i < NREGS; i++) base[i] = stb_cnt[i];
        seen = 1'b0;
        exp_q.push_back(8'h03);
        bus_start(1'b1, 16'h02BF, 8'hC3);
        for (int k = 0; k < 12; k++) begin
            @(negedge fclk);
            if (wr_stb[2] === 1'b1 && !seen) begin
                seen = 1'b1;
                exp_v = exp_q.pop_front();
                checks++; if (regs_out[23:16] !== exp_v) begin errors++; $display("FAIL mask_write_at_stb: got %h expected %h", regs_out[23:16], exp_v); end
            end
        end
        bus_end();
        idle(4);
        if (!seen) begin
            exp_q.delete();
            checks++; errors++; $display("FAIL mask_write_stb: got no strobe expected one within 12 cycles");
        end
        checks++; if (stb_cnt[2] - base[2] !== 1) begin errors++; $display("FAIL mask_write_stb_len: got %0d expected 1", stb_cnt[2] - base[2]); end
        checks++; if ((stb_cnt[0] + stb_cnt[1] + stb_cnt[3]) !== (base[0] + base[1] + base[3])) begin errors++; $display("FAIL mask_write_other_stb: got %0d expected %0d", stb_cnt[0] + stb_cnt[1] + stb_cnt[3], base[0] + base[1] + base[3]); end
        checks++; if (regs_out !== 32'h0003_5A00) begin errors++; $display("FAIL mask_write_regs: got %h expected 00035a00", regs_out); end
    endtask

    task automatic test_ext_read();
        bit ok;
        logic [7:0] exp_v;
        local_write(16'h00BF, 8'h12);
        checks++; if (ext_addr !== 8'h12) begin errors++; $display("FAIL ext_addr: got %h expected 12", ext_addr); end
        exp_q.push_back(8'h77);
        bus_start(1'b0, 16'hFFBF, 8'h00);
        wait_req(ok);
        if (!ok) begin
            exp_q.delete();
            checks++; errors++; $display("FAIL ext_read_req: got no ext_req expected one within 20 cycles");
        end else begin
            checks++; if (ext_rnw !== 1'b1) begin errors++; $display("FAIL ext_read_rnw: got %b expected 1", ext_rnw); end
            checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL ext_read_wait_low: got %b expected 0", wait_n); end
            repeat (5) @(posedge fclk);
            #1 ext_rdata = 8'h77; ext_ack = 1'b1;
            @(negedge fclk);
            checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL ext_read_wait_at_ack: got %b expected 0", wait_n); end
            @(posedge fclk);
            #1 ext_ack = 1'b0; ext_rdata = 8'h00;
            checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL ext_read_wait_release: got %b expected 1", wait_n); end
            checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL ext_read_req_drop: got %b expected 0", ext_req); end
            exp_v = exp_q.pop_front();
            checks++; if (dout !== exp_v) begin errors++; $display("FAIL ext_read_dout: got %h expected %h", dout, exp_v); end
            checks++; if (dataout !== 1'b1) begin errors++; $display("FAIL ext_read_oe: got %b expected 1", dataout); end
        end
        bus_end();
        idle(4);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ext_read_err: got %b expected 0", err); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit saw_req;
        int n;
        logic [7:0] exp_v;
        bus_start(1'b1, 16'hFFBF, 8'h3C);
        wait_req(ok);
        if (!ok) begin
            checks++; errors++; $display("FAIL tmo_write_req: got no ext_req expected one within 20 cycles");
        end else begin
            checks++; if (ext_rnw !== 1'b0) begin errors++; $display("FAIL tmo_write_rnw: got %b expected 0", ext_rnw); end
            checks++; if (ext_wdata !== 8'h3C) begin errors++; $display("FAIL tmo_write_wdata: got %h expected 3c", ext_wdata); end
            n = 0;
            while (ext_req === 1'b1 && n < 40) begin
                n++;
                @(negedge fclk);
            end
            checks++; if (n !== 15) begin errors++; $display("FAIL tmo_write_len: got %0d expected 15", n); end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_write_err: got %b expected 1", err); end
            checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL tmo_write_wait: got %b expected 1", wait_n); end
        end
        bus_end();
        idle(3);

        exp_q.push_back(8'hFF);
        bus_start(1'b0, 16'hFFBF, 8'h00);
        wait_req(ok);
        n = 0;
        while (ok && wait_n !== 1'b1 && n < 40) begin
            n++;
            @(negedge fclk);
        end
        if (!ok || wait_n !== 1'b1) begin
            exp_q.delete();
            checks++; errors++; $display("FAIL tmo_read_done: got req=%b wait_n=%b expected completed access", ok, wait_n);
        end else begin
            exp_v = exp_q.pop_front();
            checks++; if (dout !== exp_v) begin errors++; $display("FAIL tmo_read_dout: got %h expected %h", dout, exp_v); end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_read_err: got %b expected 1", err); end
        end
        bus_end();
        idle(3);

        saw_req = 1'b0;
        bus_start(1'b1, 16'hFFBF, 8'h80);
        for (int k = 0; k < 10; k++) begin
            @(negedge fclk);
            if (ext_req === 1'b1) saw_req = 1'b1;
        end
        bus_end();
        idle(3);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL err_clear_no_req: got %b expected 0", saw_req); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] exp_v;
        local_write(16'h03BF, 8'h44);
        checks++; if (regs_out[31:24] !== 8'h44) begin errors++; $display("FAIL rstmid_pre_write: got %h expected 44", regs_out[31:24]); end
        bus_start(1'b0, 16'hFFBF, 8'h00);
        wait_req(ok);
        if (!ok) begin
            checks++; errors++; $display("FAIL rstmid_req: got no ext_req expected one within 20 cycles");
        end
        @(posedge fclk);
        #1 rst = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(posedge fclk);
        #1 rst = 1'b0; ext_ack = 1'b1; ext_rdata = 8'h99;
        repeat (2) @(posedge fclk);
        #1 ext_ack = 1'b0; ext_rdata = 8'h00;
        @(negedge fclk);
        checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL rstmid_ext_req: got %b expected 0", ext_req); end
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rstmid_wait_n: got %b expected 1", wait_n); end
        checks++; if (regs_out !== RSTV) begin errors++; $display("FAIL rstmid_regs: got %h expected %h", regs_out, RSTV); end
        checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL rstmid_ack_ignored: got %h expected ff", dout); end

        exp_q.push_back(8'h21);
        bus_start(1'b0, 16'hFFBF, 8'h00);
        wait_req(ok);
        if (!ok) begin
            exp_q.delete();
            checks++; errors++; $display("FAIL rstmid_idle: got no ext_req expected one within 20 cycles");
        end else begin
            repeat (2) @(posedge fclk);
            #1 ext_rdata = 8'h21; ext_ack = 1'b1;
            @(posedge fclk);
            #1 ext_ack = 1'b0; ext_rdata = 8'h00;
            exp_v = exp_q.pop_front();
            checks++; if (dout !== exp_v) begin errors++; $display("FAIL rstmid_new_read: got %h expected %h", dout, exp_v); end
        end
        bus_end();
        idle(4);
    endtask

    task automatic test_unmapped();
        int  base;
        bit  saw_req;
        base = stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3];
        bus_start(1'b0, 16'h07BF, 8'h00);
        repeat (2) @(negedge fclk);
        checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL unmapped_read: got %h expected ff", dout); end
        checks++; if (dataout !== 1'b1) begin errors++; $display("FAIL unmapped_oe: got %b expected 1", dataout); end
        bus_end();
        idle(3);
        saw_req = 1'b0;
        bus_start(1'b1, 16'h07BF, 8'h55);
        for (int k = 0; k < 10; k++) begin
            @(negedge fclk);
            if (ext_req === 1'b1) saw_req = 1'b1;
        end
        bus_end();
        idle(3);
        checks++; if ((stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3]) !== base) begin errors++; $display("FAIL unmapped_stb: got %0d expected %0d", stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3], base); end
        checks++; if (regs_out !== RSTV) begin errors++; $display("FAIL unmapped_regs: got %h expected %h", regs_out, RSTV); end
        checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL unmapped_no_req: got %b expected 0", saw_req); end
        bus_start(1'b0, 16'h01BE, 8'h00);
        repeat (2) @(negedge fclk);
        checks++; if (porthit !== 1'b0) begin errors++; $display("FAIL miss_porthit: got %b expected 0", porthit); end
        checks++; if (dataout !== 1'b0) begin errors++; $display("FAIL miss_oe: got %b expected 0", dataout); end
        bus_end();
        idle(3);
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_ext_read();
        test_timeout();
        test_reset_mid();
        test_unmapped();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
